// File: rtl/mesh_drain.sv
// mesh_drain: snapshots the sorted mesh register array on completion and
// streams its cells out one per beat in snake or row-major order.
module mesh_drain #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int SNAKE = 1,
    localparam int N    = ROWS * COLS,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*WIDTH-1:0]     mesh_flat,
    input  logic                   mesh_done,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [IW-1:0]          out_index,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic          ONE  = (N == 1);

    state_t               state_q;
    logic [N*WIDTH-1:0]   snap_q;
    logic [IW-1:0]        k_q;
    logic [WIDTH-1:0]     data_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 ovr_q;

    logic                 hs;
    logic                 fin;
    logic [WIDTH-1:0]     data_d;

    // Cell (flat index) holding the k-th element of the read-out order.
    function automatic int cell_of(input int k);
        int r;
        int j;
        int c;
        r = k / COLS;
        j = k % COLS;
        c = (SNAKE != 0 && (r % 2) == 1) ? (COLS - 1 - j) : j;
        return r * COLS + c;
    endfunction

    assign hs  = valid_q & out_ready;
    assign fin = hs && (k_q == LAST);

    // Element following the current one, fetched from the snapshot.
    always_comb begin
        data_d = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(k_q) + 1) begin
                data_d = snap_q[cell_of(i)*WIDTH +: WIDTH];
            end
        end
    end

    // Capture / stream FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mesh_done) begin
                        snap_q  <= mesh_flat;
                        k_q     <= '0;
                        data_q  <= mesh_flat[cell_of(0)*WIDTH +: WIDTH];
                        valid_q <= 1'b1;
                        last_q  <= ONE;
                        busy_q  <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (fin) begin
                        if (mesh_done) begin
                            snap_q <= mesh_flat;
                            k_q    <= '0;
                            data_q <= mesh_flat[cell_of(0)*WIDTH +: WIDTH];
                            last_q <= ONE;
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (mesh_done) begin
                            ovr_q <= 1'b1;
                        end
                        if (hs) begin
                            k_q    <= k_q + 1'b1;
                            data_q <= data_d;
                            last_q <= ((k_q + 1'b1) == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_index = k_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule
